// File: rtl/bmi_frame_sequencer.sv
// Collects a 3-byte {weight, height} frame, presents it to the BMI classifier in
// one update, samples the classifier flags after a settle delay and returns a valid/ready result.
module bmi_frame_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [7:0]  TIMEOUT       = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [8:0] weight,
  output logic [7:0] height,
  input  logic       overweight_i,
  input  logic       normal_i,
  input  logic       underweight_i,
  input  logic       error_i,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [1:0] res_class,
  output logic       frame_err
);

  localparam int unsigned    SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]  SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {W_HI, W_LO, HGT, SETTLE, RESULT} state_e;

  state_e        state_q,  state_d;
  logic          sh_w8_q,  sh_w8_d;
  logic [7:0]    sh_wlo_q, sh_wlo_d;
  logic [8:0]    weight_q, weight_d;
  logic [7:0]    height_q, height_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [7:0]    idle_q,   idle_d;
  logic [1:0]    class_q,  class_d;
  logic          err_q,    err_d;

  logic       accept;
  logic       timeout_hit;
  logic [7:0] idle_inc;
  logic [1:0] flag_class;

  // Gated with rst so no byte is ever handshaken while reset is held.
  assign in_ready    = !rst && (state_q == W_HI || state_q == W_LO || state_q == HGT);
  assign accept      = in_valid && in_ready;
  assign timeout_hit = (TIMEOUT != 8'd0) && (idle_q == TIMEOUT - 8'd1);
  assign idle_inc    = (idle_q == 8'hFF) ? idle_q : idle_q + 8'd1;

  always_comb begin
    case ({overweight_i, normal_i, underweight_i, error_i})
      4'b1000: flag_class = 2'b10;
      4'b0100: flag_class = 2'b01;
      4'b0010: flag_class = 2'b00;
      default: flag_class = 2'b11;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state_q;
    sh_w8_d  = sh_w8_q;
    sh_wlo_d = sh_wlo_q;
    weight_d = weight_q;
    height_d = height_q;
    settle_d = settle_q;
    idle_d   = idle_q;
    class_d  = class_q;
    err_d    = 1'b0;

    case (state_q)
      W_HI: begin
        if (accept) begin
          if (in_data[7:1] != 7'd0) begin
            err_d = 1'b1;
          end else begin
            sh_w8_d = in_data[0];
            idle_d  = 8'd0;
            state_d = W_LO;
          end
        end
      end
      W_LO, HGT: begin
        if (accept) begin
          idle_d = 8'd0;
          if (state_q == W_LO) begin
            sh_wlo_d = in_data;
            state_d  = HGT;
          end else begin
            weight_d = {sh_w8_q, sh_wlo_q};
            height_d = in_data;
            settle_d = SETTLE_LOAD;
            state_d  = SETTLE;
          end
        end else if (timeout_hit) begin
          // Abandon the partial frame; operands already shown to the classifier stay put.
          err_d    = 1'b1;
          sh_w8_d  = 1'b0;
          sh_wlo_d = 8'd0;
          idle_d   = 8'd0;
          state_d  = W_HI;
        end else begin
          idle_d = idle_inc;
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          class_d = flag_class;
          state_d = RESULT;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      RESULT: begin
        if (res_ready) state_d = W_HI;
      end
      default: state_d = W_HI;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= W_HI;
      sh_w8_q  <= 1'b0;
      sh_wlo_q <= 8'd0;
      weight_q <= 9'd0;
      height_q <= 8'd0;
      settle_q <= '0;
      idle_q   <= 8'd0;
      class_q  <= 2'b00;
      err_q    <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
      state_q  <= state_d;
      sh_w8_q  <= sh_w8_d;
      sh_wlo_q <= sh_wlo_d;
      weight_q <= weight_d;
      height_q <= height_d;
      settle_q <= settle_d;
      idle_q   <= idle_d;
      class_q  <= class_d;
      err_q    <= err_d;
    end
  end

  assign weight    = weight_q;
  assign height    = height_q;
  assign res_valid = (state_q == RESULT);
  assign res_class = class_q;
  assign frame_err = err_q;

endmodule
